// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: bus widths, LSB type codes, grant codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int TYPE_W = 7;

   // Instruction-type codes carried on lsb_type / mem_type; 0 marks an ICache fetch.
   localparam logic [TYPE_W-1:0] TYPE_NONE = 7'd0;
   localparam logic [TYPE_W-1:0] TYPE_LB   = 7'd1;
   localparam logic [TYPE_W-1:0] TYPE_LH   = 7'd2;
   localparam logic [TYPE_W-1:0] TYPE_LW   = 7'd3;
   localparam logic [TYPE_W-1:0] TYPE_LBU  = 7'd4;
   localparam logic [TYPE_W-1:0] TYPE_LHU  = 7'd5;
   localparam logic [TYPE_W-1:0] TYPE_SB   = 7'd6;
   localparam logic [TYPE_W-1:0] TYPE_SH   = 7'd7;
   localparam logic [TYPE_W-1:0] TYPE_SW   = 7'd8;

   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_LSB  = 2'd1,
      GRANT_IC   = 2'd2
   } grant_e;

   function automatic logic is_store(input logic [TYPE_W-1:0] t);
      return (t == TYPE_SB) || (t == TYPE_SH) || (t == TYPE_SW);
   endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Priority selector: store first, then a starved ICache, then loads, then ICache.
// Latency: combinational.
// Backpressure: none; the caller only samples the grant while idle.
module mem_arb_select
   import mem_arbiter_pkg::*;
(
   input  logic   lsb_valid_i,
   input  logic   lsb_store_i,
   input  logic   ic_valid_i,
   input  logic   ic_starved_i,
   output grant_e grant_o
);

   // First match wins; stores are committed work and always go ahead of fetches.
   always_comb begin
      grant_o = GRANT_NONE;
      if (lsb_valid_i && lsb_store_i) begin
         grant_o = GRANT_LSB;
      end else if (ic_valid_i && ic_starved_i) begin
         grant_o = GRANT_IC;
      end else if (lsb_valid_i) begin
         grant_o = GRANT_LSB;
      end else if (ic_valid_i) begin
         grant_o = GRANT_IC;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates ICache and LSB onto the byte-serial memory controller, routes completions back.
// Latency: request to mem_valid 1 cycle; mem_done to x_done 1 cycle; one GAP cycle between transactions.
// Backpressure: requesters hold valid until done; rdy=0 freezes every register.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              flush,
   input  logic              ic_valid,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic              ic_done,
   output logic [DATA_W-1:0] ic_data,
   input  logic              lsb_valid,
   input  logic [ADDR_W-1:0] lsb_addr,
   input  logic [DATA_W-1:0] lsb_wdata,
   input  logic [TYPE_W-1:0] lsb_type,
   output logic              lsb_done,
   output logic [DATA_W-1:0] lsb_rdata,
   output logic              mem_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [TYPE_W-1:0] mem_type,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_BUSY_LSB = 2'd1;
   localparam logic [1:0] ST_BUSY_IC  = 2'd2;
   localparam logic [1:0] ST_GAP      = 2'd3;

   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   logic [1:0]        state_q,     state_d;
   logic [CNT_W-1:0]  starve_q,    starve_d;
   logic              cancel_q,    cancel_d;
   logic              mem_valid_q, mem_valid_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [TYPE_W-1:0] mem_type_q,  mem_type_d;
   logic              ic_done_q,   ic_done_d;
   logic [DATA_W-1:0] ic_data_q,   ic_data_d;
   logic              lsb_done_q,  lsb_done_d;
   logic [DATA_W-1:0] lsb_rdata_q, lsb_rdata_d;

   grant_e grant;
   logic   ic_starved;
   logic   cur_store;
   logic   cancellable;
   logic   suppress;

   assign ic_starved  = (starve_q == STARVE_MAX);
   assign cur_store   = is_store(mem_type_q);
   // Stores are committed state and must reach the LSB even across a flush.
   assign cancellable = (state_q == ST_BUSY_IC) || ((state_q == ST_BUSY_LSB) && !cur_store);
   assign suppress    = cancel_q || (flush && cancellable);

   mem_arb_select u_select (
      .lsb_valid_i  (lsb_valid),
      .lsb_store_i  (is_store(lsb_type)),
      .ic_valid_i   (ic_valid),
      .ic_starved_i (ic_starved),
      .grant_o      (grant)
   );

   // Next-state: grant in IDLE, wait for mem_done in BUSY, single idle cycle in GAP.
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      cancel_d    = cancel_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_type_d  = mem_type_q;
      ic_done_d   = 1'b0;
      ic_data_d   = ic_data_q;
      lsb_done_d  = 1'b0;
      lsb_rdata_d = lsb_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (grant == GRANT_LSB) begin
               state_d     = ST_BUSY_LSB;
               mem_valid_d = 1'b1;
               mem_addr_d  = lsb_addr;
               mem_wdata_d = lsb_wdata;
               mem_type_d  = lsb_type;
               if (ic_valid && !ic_starved) begin
                  starve_d = starve_q + 1'b1;
               end
            end else if (grant == GRANT_IC) begin
               state_d     = ST_BUSY_IC;
               mem_valid_d = 1'b1;
               mem_addr_d  = ic_addr;
               mem_wdata_d = '0;
               mem_type_d  = TYPE_NONE;
               starve_d    = '0;
            end
         end
         ST_BUSY_LSB, ST_BUSY_IC: begin
            if (flush && cancellable) begin
               cancel_d = 1'b1;
            end
            if (mem_done) begin
               state_d     = ST_GAP;
               mem_valid_d = 1'b0;
               if (!suppress) begin
                  if (state_q == ST_BUSY_IC) begin
                     ic_done_d = 1'b1;
                     ic_data_d = mem_rdata;
                  end else begin
                     lsb_done_d  = 1'b1;
                     lsb_rdata_d = cur_store ? '0 : mem_rdata;
                  end
               end
            end
         end
         ST_GAP: begin
            state_d  = ST_IDLE;
            cancel_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers: synchronous reset, otherwise advance only while rdy is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         starve_q    <= '0;
         cancel_q    <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_type_q  <= '0;
         ic_done_q   <= 1'b0;
         ic_data_q   <= '0;
         lsb_done_q  <= 1'b0;
         lsb_rdata_q <= '0;
      end else if (rdy) begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         cancel_q    <= cancel_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_type_q  <= mem_type_d;
         ic_done_q   <= ic_done_d;
         ic_data_q   <= ic_data_d;
         lsb_done_q  <= lsb_done_d;
         lsb_rdata_q <= lsb_rdata_d;
      end
   end

   assign mem_valid = mem_valid_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_type  = mem_type_q;
   assign ic_done   = ic_done_q;
   assign ic_data   = ic_data_q;
   assign lsb_done  = lsb_done_q;
   assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table of single/dual transactions plus hand sequences.
// Latency: n/a.
// Backpressure: bench plays both requesters and the memory controller.
`timescale 1ns/1ps
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy, flush;
   logic        ic_valid, ic_done;
   logic [31:0] ic_addr, ic_data;
   logic        lsb_valid, lsb_done;
   logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
   logic [6:0]  lsb_type, mem_type;
   logic        mem_valid, mem_done;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .ic_valid(ic_valid), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
      .lsb_valid(lsb_valid), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_type(lsb_type),
      .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_type(mem_type),
      .mem_done(mem_done), .mem_rdata(mem_rdata)
   );

   int checks = 0;
   int errors = 0;

   typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [6:0] mtype; } grant_t;
   typedef struct { logic is_ic; logic [31:0] data; } resp_t;
   typedef struct {
      logic ic_req; logic lsb_req; logic [6:0] ltype;
      logic [31:0] ic_addr; logic [31:0] lsb_addr; logic [31:0] wdata; logic [31:0] rdata;
      int flush_mode; logic lsb_first; logic done1; logic [31:0] data1;
      logic has2; logic [31:0] data2;
   } vec_t;

   grant_t grant_q[$];
   resp_t  resp_q[$];
   logic   mem_valid_prev = 1'b0;
   vec_t   vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Scoreboard: every new grant and every done pulse is matched against queued expectations.
   always @(negedge clk) begin : mon
      resp_t  r;
      grant_t g;
      if (ic_done && lsb_done) begin
         checks++;
         errors++;
         $display("FAIL both_done: ic_done=1 lsb_done=1 expected at most one");
      end else if (ic_done || lsb_done) begin
         if (resp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: ic_done=%b lsb_done=%b expected none", ic_done, lsb_done);
         end else begin
            r = resp_q.pop_front();
            chk_b("done_is_ic", ic_done, r.is_ic);
            chk(r.is_ic ? "ic_data" : "lsb_rdata", r.is_ic ? ic_data : lsb_rdata, r.data);
         end
      end
      if (mem_valid && !mem_valid_prev) begin
         if (grant_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: addr=%h expected no grant", mem_addr);
         end else begin
            g = grant_q.pop_front();
            chk("grant_addr", mem_addr, g.addr);
            chk("grant_wdata", mem_wdata, g.wdata);
            chk("grant_type", {25'b0, mem_type}, {25'b0, g.mtype});
         end
      end
      mem_valid_prev = mem_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; rdy = 1'b1; flush = 1'b0; mem_done = 1'b0; mem_rdata = '0;
      ic_valid = 1'b0; ic_addr = '0;
      lsb_valid = 1'b0; lsb_addr = '0; lsb_wdata = '0; lsb_type = '0;
      tick();
      tick();
      rst = 1'b0;
      chk_b("rst_mem_valid", mem_valid, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk_b("rst_ic_done", ic_done, 1'b0);
      chk_b("rst_lsb_done", lsb_done, 1'b0);
   endtask

   // Count cycles until mem_valid rises, bounded so a missing grant cannot hang the run.
   task automatic wait_grant(input string name, input int exp_n);
      int n = 0;
      while (!mem_valid && n < 12) begin
         tick();
         n++;
      end
      chk(name, n, exp_n);
   endtask

   // Controller model: hold off for lat cycles, optionally flush, then pulse mem_done.
   task automatic serve(input int lat, input logic [31:0] rdata, input int fm);
      for (int k = 0; k < lat; k++) begin
         flush = (fm == 1 && k == 2);
         tick();
      end
      flush = (fm == 2);
      mem_done = 1'b1;
      mem_rdata = rdata;
      tick();
      mem_done = 1'b0;
      mem_rdata = '0;
      flush = 1'b0;
   endtask

   initial begin
      // ic_req lsb_req ltype ic_addr lsb_addr wdata rdata flush lsb_first done1 data1 has2 data2
      vecs[0] = '{1'b1, 1'b0, TYPE_NONE, 32'h1000, 32'h0,  32'h0,        32'hDEADBEEF, 0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
      vecs[1] = '{1'b1, 1'b1, TYPE_SW,   32'h2000, 32'h20, 32'h12345678, 32'hAAAA5555, 0, 1'b1, 1'b1, 32'h0,        1'b1, 32'h0BADF00D};
      vecs[2] = '{1'b0, 1'b1, TYPE_LW,   32'h0,    32'h40, 32'h0,        32'hCAFEF00D, 0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0};
      vecs[3] = '{1'b1, 1'b1, TYPE_LB,   32'h3000, 32'h44, 32'h0,        32'h0000007F, 0, 1'b1, 1'b1, 32'h0000007F, 1'b1, 32'h11112222};
      vecs[4] = '{1'b1, 1'b0, TYPE_NONE, 32'h1004, 32'h0,  32'h0,        32'h5555AAAA, 1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
      vecs[5] = '{1'b0, 1'b1, TYPE_LB,   32'h0,    32'h48, 32'h0,        32'h00000080, 1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      vecs[6] = '{1'b0, 1'b1, TYPE_SW,   32'h0,    32'h50, 32'h87654321, 32'hFFFFFFFF, 1, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0};
      vecs[7] = '{1'b1, 1'b1, TYPE_SH,   32'h1008, 32'h54, 32'h0000BEEF, 32'h12340000, 1, 1'b1, 1'b1, 32'h0,        1'b1, 32'h33334444};
      vecs[8] = '{1'b0, 1'b1, TYPE_LHU,  32'h0,    32'h58, 32'h0,        32'h0000FFFF, 2, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      vecs[9] = '{1'b1, 1'b0, TYPE_NONE, 32'h100C, 32'h0,  32'h0,        32'h99998888, 2, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};

      for (int i = 0; i < 10; i++) begin
         do_reset();
         ic_valid = vecs[i].ic_req;  ic_addr = vecs[i].ic_addr;
         lsb_valid = vecs[i].lsb_req; lsb_addr = vecs[i].lsb_addr;
         lsb_wdata = vecs[i].wdata;  lsb_type = vecs[i].ltype;
         if (vecs[i].lsb_first) grant_q.push_back('{vecs[i].lsb_addr, vecs[i].wdata, vecs[i].ltype});
         else                   grant_q.push_back('{vecs[i].ic_addr, 32'h0, TYPE_NONE});
         wait_grant($sformatf("v%0d_grant1_latency", i), 1);
         if (vecs[i].done1) resp_q.push_back('{!vecs[i].lsb_first, vecs[i].data1});
         serve(5, vecs[i].rdata, vecs[i].flush_mode);
         if (vecs[i].lsb_first) lsb_valid = 1'b0;
         else                   ic_valid = 1'b0;
         if (vecs[i].has2) begin
            grant_q.push_back('{vecs[i].ic_addr, 32'h0, TYPE_NONE});
            wait_grant($sformatf("v%0d_grant2_after_done", i), 2);
            resp_q.push_back('{1'b1, vecs[i].data2});
            serve(3, vecs[i].data2, 0);
            ic_valid = 1'b0;
         end
         tick();
         tick();
         chk($sformatf("v%0d_resp_pending", i), resp_q.size(), 0);
         chk($sformatf("v%0d_grant_pending", i), grant_q.size(), 0);
      end

      // Starvation: ICache held while loads stream; expect L,L,L,L,IC,L then IC once loads stop.
      begin
         logic is_ic_pat [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
         do_reset();
         ic_valid = 1'b1; ic_addr = 32'h4000;
         lsb_valid = 1'b1; lsb_addr = 32'h100; lsb_type = TYPE_LW; lsb_wdata = '0;
         for (int i = 0; i < 7; i++) begin
            if (is_ic_pat[i]) grant_q.push_back('{ic_addr, 32'h0, TYPE_NONE});
            else              grant_q.push_back('{lsb_addr, 32'h0, TYPE_LW});
            wait_grant($sformatf("starve_g%0d_latency", i), (i == 0) ? 1 : 2);
            resp_q.push_back('{is_ic_pat[i], 32'hA0000000 + i});
            serve(2, 32'hA0000000 + i, 0);
            if (is_ic_pat[i]) begin
               if (i == 6) ic_valid = 1'b0;
               else        ic_addr = ic_addr + 32'h4;
            end else begin
               if (i == 5) lsb_valid = 1'b0;
               else        lsb_addr = lsb_addr + 32'h4;
            end
         end
         tick();
         tick();
         chk("starve_grant_pending", grant_q.size(), 0);
         chk("starve_resp_pending", resp_q.size(), 0);
      end

      // rdy low across mem_done and flush: nothing moves; response delivered once on resume.
      do_reset();
      lsb_valid = 1'b1; lsb_addr = 32'h60; lsb_type = TYPE_LW;
      grant_q.push_back('{32'h60, 32'h0, TYPE_LW});
      wait_grant("rdy_grant_latency", 1);
      tick();
      rdy = 1'b0; mem_done = 1'b1; mem_rdata = 32'h77778888; flush = 1'b1;
      tick(); tick(); tick();
      chk_b("rdy_freeze_mem_valid", mem_valid, 1'b1);
      chk("rdy_freeze_mem_addr", mem_addr, 32'h60);
      rdy = 1'b1; flush = 1'b0;
      resp_q.push_back('{1'b0, 32'h77778888});
      tick();
      mem_done = 1'b0; mem_rdata = '0; lsb_valid = 1'b0;
      tick(); tick(); tick();
      chk("rdy_resp_pending", resp_q.size(), 0);
      chk_b("rdy_mem_valid_dropped", mem_valid, 1'b0);

      // Reset in BUSY_LSB abandons the store silently; arbiter is back in IDLE right away.
      do_reset();
      lsb_valid = 1'b1; lsb_addr = 32'h70; lsb_wdata = 32'hFEEDFACE; lsb_type = TYPE_SW;
      grant_q.push_back('{32'h70, 32'hFEEDFACE, TYPE_SW});
      wait_grant("rst_mid_grant_latency", 1);
      tick();
      rst = 1'b1; lsb_valid = 1'b0;
      tick();
      rst = 1'b0;
      chk_b("rst_mid_mem_valid", mem_valid, 1'b0);
      chk("rst_mid_mem_addr", mem_addr, 32'h0);
      chk("rst_mid_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mid_mem_type", {25'b0, mem_type}, 32'h0);
      chk_b("rst_mid_lsb_done", lsb_done, 1'b0);
      mem_done = 1'b1; mem_rdata = 32'h13572468;
      tick();
      mem_done = 1'b0; mem_rdata = '0;
      ic_valid = 1'b1; ic_addr = 32'h1010;
      grant_q.push_back('{32'h1010, 32'h0, TYPE_NONE});
      wait_grant("rst_mid_idle_grant_latency", 1);
      resp_q.push_back('{1'b1, 32'h24681357});
      serve(2, 32'h24681357, 0);
      ic_valid = 1'b0;
      tick(); tick();
      chk("final_resp_pending", resp_q.size(), 0);
      chk("final_grant_pending", grant_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the requesters (ICache miss path, LSB) and the byte-serial memory controller.
- Grants at most one transaction at a time and presents it to the controller with registered signals.
- Routes the controller's completion back to the winning requester.
- Enforces store-first priority, bounded ICache starvation, and flush suppression of speculative responses.

Parameters:
- STARVE_LIMIT, 4: consecutive LSB grants allowed while an ICache request waits; the next grant goes to ICache.
- CNT_W, 3: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state and outputs
- flush  in  1  mispredict flush pulse
- ic_valid  in  1  ICache request, level-held until ic_done
- ic_addr  in  32  ICache fetch address
- ic_done  out  1  one-cycle response pulse to ICache
- ic_data  out  32  fetched word, valid with ic_done
- lsb_valid  in  1  LSB request, level-held until lsb_done
- lsb_addr  in  32  LSB address
- lsb_wdata  in  32  store data
- lsb_type  in  7  instruction-type code (LB..SW)
- lsb_done  out  1  one-cycle completion pulse to LSB
- lsb_rdata  out  32  load result, valid with lsb_done
- mem_valid  out  1  request to memory controller, held until mem_done
- mem_addr  out  32  granted address
- mem_wdata  out  32  granted store data; 0 for fetches
- mem_type  out  7  granted type; 0 for fetches
- mem_done  in  1  controller completion pulse
- mem_rdata  in  32  controller read data, valid with mem_done

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; starve_cnt=0; cancel=0; all outputs 0. Reset mid-transaction abandons it with no done pulse to anyone.
- rdy=0: no register changes, including on mem_done/flush edges.
- States:
  - IDLE: arbitrate.
  - BUSY_LSB, BUSY_IC: mem_valid held high.
  - GAP: one idle cycle so the controller returns to its idle state.
- IDLE arbitration, evaluated each edge, first match wins:
  1. lsb_valid with store type (SB/SH/SW) → BUSY_LSB.
  2. ic_valid and starve_cnt==STARVE_LIMIT → BUSY_IC.
  3. lsb_valid (load) → BUSY_LSB.
  4. ic_valid → BUSY_IC.
- On a grant, the same edge registers mem_addr/mem_wdata/mem_type and sets mem_valid=1. Latency from request to mem_valid is 1 cycle.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on an LSB grant while ic_valid=1.
  - Clears on an ICache grant.
  - Otherwise unchanged.
- BUSY_x on mem_done:
  - mem_valid→0 and state→GAP.
  - Unless cancel is set, pulse x_done=1 for exactly one cycle with x_data/lsb_rdata=mem_rdata.
  - lsb_done for stores carries lsb_rdata=0.
- GAP: ignores all requests; → IDLE next edge; cancel cleared. A requester sees done then must drop or change valid; this arbitrates no earlier than 2 cycles after done.
- Flush:
  - In BUSY_IC, or BUSY_LSB with a load, sets cancel. The transaction still runs to mem_done (byte streams are not abortable), but the done pulse is suppressed.
  - Stores are committed and are never cancelled.
  - Flush in IDLE/GAP has no effect on the arbiter; requesters drop their own valids.
  - Flush coincident with mem_done also suppresses the done pulse.
- mem_done while in IDLE/GAP: ignored.
- Done pulses are registered and last exactly one cycle; ic_done and lsb_done are never high together.

Decomposition:
- Shared package (utils.v): ADDR_RANGE, DATA_RANGE, instruction-type codes (LB, LH, LW, LBU, LHU, SB, SH, SW), and an is_store helper macro.
- Arbiter state encodings are local defines.
- No sub-module is needed. The priority/starvation selector may optionally be split out as mem_arb_select (combinational, 4 inputs → grant code).

Test Plan:
- ICache-only fetch: ic_valid, addr 0x1000; mem_done with rdata 0xDEADBEEF 5 cycles after grant → mem_valid high 1 cycle after request; ic_done=1 for 1 cycle with ic_data=0xDEADBEEF; GAP; next grant ≥2 cycles later.
- Simultaneous SW (0x20, 0x12345678) and ic_valid → store granted first with mem_type=SW, mem_wdata=0x12345678; ICache granted after the store's GAP.
- Starvation: ic_valid held while LSB issues 6 back-to-back loads → grants L,L,L,L,IC,L (STARVE_LIMIT=4); starve_cnt returns to 0 after the IC grant.
- Flush during BUSY_IC (and separately during an LB) → mem transaction completes, no ic_done/lsb_done pulse, GAP entered. Flush during an SW → lsb_done still pulses.
- rdy=0 for 3 cycles spanning mem_done=1 → no state change; once rdy returns with mem_done reasserted, the response is delivered once.
- rst asserted in BUSY_LSB → next cycle all outputs 0, state IDLE, no lsb_done.
